uart_tx_fifo: RTL and testbench

Serial transmitter that drives the board's FTDI TX line. Today that line is tied low in the SOC top.
- Upstream side: the processor-side IO logic pushes bytes through a valid/ready handshake into a small FIFO.
- Serial side: an 8N1 shifter drains the FIFO at a fixed baud rate.
- It sits directly downstream of the CPU's memory-mapped IO writes. Its txd output feeds ftdi_txd.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
package uart_pkg;

    // Serial-side frame phases.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;

    // Clock cycles spent on each serial bit (integer division, truncated).
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop strobes and an occupancy count.
// A push while full is dropped even if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Write the accepted byte into the slot at the write pointer.
    // NOTE: the storage array is deliberately not reset; the pointers and count
    // alone decide which entries are valid, so the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Advance pointers (wrapping modulo DEPTH) and track occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 serial transmitter fed by a small byte FIFO. Frames are sent
// back-to-back while the FIFO holds data; txd idles high.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        txd
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam int BITW         = $clog2(DATA_BITS);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BITW-1:0] BIT_LAST  = BITW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end

    state_t                 state;
    logic [BW-1:0]          baud_cnt;
    logic [BITW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic [DATA_BITS-1:0]   head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   bit_done;
    logic                   pop;

    assign bit_done = (baud_cnt == BAUD_LAST);
    // Take the next byte when idle, or at the very end of a stop bit so the
    // following start bit begins with no idle gap.
    assign pop      = !fifo_empty && ((state == IDLE) || (state == STOP && bit_done));
    assign tx_ready = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_valid),
        .wr_data (tx_data),
        .pop     (pop),
        .rd_data (head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Frame sequencer: start bit, eight data bits LSB first, stop bit.
    // NOTE: txd is driven from a register rather than decoded from the state so
    // the pin never glitches between bit boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        shift <= head;
                        txd   <= 1'b0;
                        state <= START;
                    end else begin
                        txd <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        txd      <= shift[0];
                        shift    <= shift >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            txd     <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= head;
                            txd   <= 1'b0;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-based frame model is compared
// against the DUT every cycle, a line receiver decodes txd, and directed
// scenarios pin literal timing points.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ_HZ = 1000;
    localparam int BAUD_RATE   = 250;
    localparam int FIFO_DEPTH  = 8;
    localparam int CPB         = 4;
    localparam int FRAME       = 10 * CPB;
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    tx_data = 8'h00;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [LW-1:0] fifo_level;
    logic          busy;
    logic          txd;

    uart_tx_fifo #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD_RATE   (BAUD_RATE),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .busy       (busy),
        .txd        (txd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];       // bytes waiting in the FIFO
    logic [7:0] acc_log[$];   // every byte accepted, in order
    logic [7:0] rx_q[$];      // bytes decoded from txd
    bit         m_active = 1'b0;
    int         m_pos = 0;    // cycles since the current frame's start edge
    logic [7:0] m_cur = 8'h00;
    bit         chk_en = 1'b0;
    bit         rx_en = 1'b0;
    int         max_level = 0;

    // Line level of a frame at serial bit slot k (0 = start, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic exp_txd();
        if (!m_active) return 1'b1;
        return frame_bit(m_cur, m_pos / CPB);
    endfunction

    initial forever begin
        bit push_ok;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            push_ok = tx_valid && (m_q.size() != FIFO_DEPTH);
            if (m_active) m_pos++;
            if ((!m_active || m_pos == FRAME) && m_q.size() != 0) begin
                m_cur    = m_q.pop_front();
                m_pos    = 0;
                m_active = 1'b1;
            end else if (m_active && m_pos == FRAME) begin
                m_active = 1'b0;
            end
            if (push_ok) begin
                m_q.push_back(tx_data);
                acc_log.push_back(tx_data);
            end
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("txd", txd, exp_txd());
            check("fifo_level", fifo_level, m_q.size());
            check("tx_ready", tx_ready, m_q.size() != FIFO_DEPTH);
            check("busy", busy, m_active || m_q.size() != 0);
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
    end

    // Line receiver sampling mid-bit.
    initial forever begin
        logic [7:0] b;
        @(negedge clk);
        if (rx_en && txd === 1'b0) begin
            repeat (CPB + 1) @(negedge clk);
            b[0] = txd;
            for (int j = 1; j < 8; j++) begin
                repeat (CPB) @(negedge clk);
                b[j] = txd;
            end
            repeat (CPB) @(negedge clk);
            check("rx_stop", txd, 1'b1);
            rx_q.push_back(b);
        end
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit hold);
        bit r;
        int budget = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        forever begin
            @(negedge clk);
            r = tx_ready;
            @(posedge clk);
            #1;
            if (r) break;
            budget++;
            if (budget > 2000) begin
                check("push_timeout", 0, 1);
                break;
            end
        end
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tx_valid = 1'b0;
        step(2);
        rst = 1'b0;
        acc_log.delete();
    endtask

    task automatic drain_and_compare(input logic [7:0] lit[$], input bit use_lit);
        int n = 0;
        while ((busy || m_active || m_q.size() != 0) && n < 4000) begin
            step(1);
            n++;
        end
        check("drain_timeout", n < 4000, 1);
        step(CPB + 2);
        check("rx_count", rx_q.size(), acc_log.size());
        for (int i = 0; i < rx_q.size() && i < acc_log.size(); i++)
            check("rx_byte", rx_q[i], acc_log[i]);
        if (use_lit) begin
            check("rx_lit_count", rx_q.size(), lit.size());
            for (int i = 0; i < rx_q.size() && i < lit.size(); i++)
                check("rx_lit_byte", rx_q[i], lit[i]);
        end
        rx_q.delete();
        acc_log.delete();
    endtask

    // ---------------- scenarios ----------------
    initial begin
        logic [7:0] lit[$];
        logic [9:0] exp55;
        int lows;

        rst = 1'b1;
        step(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        rx_en  = 1'b1;
        @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_level", fifo_level, 0);
        check("reset_ready", tx_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        step(6);

        // 1. Single byte 0x55 pushed at edge N.
        exp55 = 10'b1010101010;
        push_byte(8'h55, 1'b0);
        @(negedge clk);
        check("s1_level_after_push", fifo_level, 1);
        check("s1_txd_after_push", txd, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("s1_bit0", txd, exp55[0]);
        for (int k = 1; k < 10; k++) begin
            repeat (CPB) @(posedge clk);
            @(negedge clk);
            check($sformatf("s1_bit%0d", k), txd, exp55[k]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("s1_busy_last_stop", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("s1_busy_fall", busy, 1'b0);
        check("s1_txd_idle", txd, 1'b1);
        step(1);
        lit = '{8'h55};
        drain_and_compare(lit, 1'b1);

        // 2. Back-to-back frames, second start 40 cycles after the first.
        push_byte(8'hA5, 1'b0);
        push_byte(8'h3C, 1'b0);
        repeat (FRAME - 1) @(posedge clk);
        @(negedge clk);
        check("s2_stop_before_second", txd, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("s2_second_start", txd, 1'b0);
        check("s2_busy", busy, 1'b1);
        step(1);
        lit = '{8'hA5, 8'h3C};
        drain_and_compare(lit, 1'b1);

        // 3. Fill the FIFO with valid held, then try pushing while full.
        lit = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56, 8'h67, 8'h78, 8'h89};
        foreach (lit[i]) push_byte(lit[i], 1'b1);
        tx_data = 8'hEE;
        @(negedge clk);
        check("s3_level_full", fifo_level, FIFO_DEPTH);
        check("s3_ready_low", tx_ready, 1'b0);
        step(5);
        tx_valid = 1'b0;
        drain_and_compare(lit, 1'b1);
        check("s3_max_level", max_level, FIFO_DEPTH);

        // 4. Push 0x81 on the final stop edge while one byte is queued.
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        step(FRAME - 1);
        tx_data  = 8'h81;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        @(negedge clk);
        check("s4_level_kept", fifo_level, 1);
        check("s4_next_start", txd, 1'b0);
        step(1);
        lit = '{8'h11, 8'h22, 8'h81};
        drain_and_compare(lit, 1'b1);

        // 5. Reset during data bit 3 with two bytes queued.
        push_byte(8'hA1, 1'b0);
        push_byte(8'hB2, 1'b0);
        push_byte(8'hC3, 1'b0);
        step(15);
        rst      = 1'b1;
        tx_valid = 1'b0;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("s5_txd", txd, 1'b1);
        check("s5_level", fifo_level, 0);
        check("s5_busy", busy, 1'b0);
        check("s5_ready", tx_ready, 1'b1);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        check("s5_no_start", lows, 0);
        step(1);
        rx_q.delete();
        acc_log.delete();

        // 6. Idle line for 200 cycles after reset.
        do_reset();
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("s6_idle", lows, 0);
        step(1);

        // Randomized traffic with random gaps and held valid.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) step($urandom_range(30, 80));
            else step($urandom_range(0, 2));
            push_byte(8'($urandom), 1'($urandom_range(0, 1)));
        end
        tx_valid = 1'b0;
        lit.delete();
        drain_and_compare(lit, 1'b0);
        check("final_max_level", max_level, FIFO_DEPTH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
